// File: rtl/boid_draw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boid_draw_pkg
//  Description : Shared widths, default screen/colour constants, the per-boid
//                position-table entry type and the draw FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package boid_draw_pkg;

    localparam int FB_ADDR_W = 19;
    localparam int PX_W      = 10;
    localparam int PY_W      = 9;

    localparam int         DEF_SCREEN_W   = 640;
    localparam int         DEF_SCREEN_H   = 480;
    localparam logic [7:0] DEF_BOID_COLOR = 8'hFF;
    localparam logic [7:0] DEF_BG_COLOR   = 8'h00;

    // Last drawn position of one boid; vld means something is on screen to erase
    typedef struct packed {
        logic [9:0] px;
        logic [8:0] py;
        logic       vld;
    } boid_pix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } draw_state_e;

endpackage
`default_nettype wire

// File: rtl/boid_draw_if.sv
`default_nettype none
// ============================================================================
//  Module      : boid_draw_if
//  Description : Boid update handshake plus framebuffer write-port bundle.
//                master = upstream/arbiter side, slave = boid_draw.
//  Revision    : 1.0  initial release
// ============================================================================
interface boid_draw_if #(
    parameter int IDX_W = 6
);
    import boid_draw_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [IDX_W-1:0]     in_idx;
    logic [31:0]          in_x;
    logic [31:0]          in_y;
    logic                 fb_busy;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [7:0]           fb_data;
    logic                 draw_done;

    modport master (
        output in_valid, in_idx, in_x, in_y, fb_busy,
        input  in_ready, fb_we, fb_addr, fb_data, draw_done
    );

    modport slave (
        input  in_valid, in_idx, in_x, in_y, fb_busy,
        output in_ready, fb_we, fb_addr, fb_data, draw_done
    );

endinterface
`default_nettype wire

// File: rtl/boid_draw_pix_addr.sv
`default_nettype none
// ============================================================================
//  Module      : boid_pix_addr
//  Description : Applies a 2x2 sprite offset to a pixel, flags whether the
//                result is on screen and forms its framebuffer address
//                py*640 + px using shifts only.
//  Revision    : 1.0  initial release
// ============================================================================
module boid_pix_addr
    import boid_draw_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  wire logic [15:0]          px,
    input  wire logic [15:0]          py,
    input  wire logic [1:0]           ofs,
    output logic                      on_screen,
    output logic [FB_ADDR_W-1:0]      addr
);

    // One extra bit so px=65535 plus offset clips instead of wrapping to 0
    logic [16:0]          w_x;
    logic [16:0]          w_y;
    logic [FB_ADDR_W-1:0] w_row;

    assign w_x = {1'b0, px} + {16'd0, ofs[0]};
    assign w_y = {1'b0, py} + {16'd0, ofs[1]};

    assign on_screen = (w_x < 17'(SCREEN_W)) && (w_y < 17'(SCREEN_H));

    // Row stride is 640 = 512 + 128; address is only meaningful when on_screen
    assign w_row = {{(FB_ADDR_W-PY_W){1'b0}}, w_y[PY_W-1:0]};
    assign addr  = (w_row << 9) + (w_row << 7)
                 + {{(FB_ADDR_W-PX_W){1'b0}}, w_x[PX_W-1:0]};

endmodule
`default_nettype wire

// File: rtl/boid_draw.sv
`default_nettype none
// ============================================================================
//  Module      : boid_draw
//  Description : Framebuffer write stage. For each boid update, erases the
//                boid's previously drawn pixel(s), draws the new ones, then
//                records the new position in a per-boid table.
//                Option macro BOID_DRAW_SPRITE_EN: 2x2 sprite per boid
//                (undefined: single pixel).
//  Revision    : 1.0  initial release
// ============================================================================
module boid_draw
    import boid_draw_pkg::*;
#(
    parameter int         N_BOIDS    = 64,
    parameter int         IDX_W      = $clog2(N_BOIDS),
    parameter int         SCREEN_W   = DEF_SCREEN_W,
    parameter int         SCREEN_H   = DEF_SCREEN_H,
    parameter logic [7:0] BOID_COLOR = DEF_BOID_COLOR,
    parameter logic [7:0] BG_COLOR   = DEF_BG_COLOR
) (
    input  wire logic  clk,
    input  wire logic  reset,
    boid_draw_if.slave bus
);

`ifdef BOID_DRAW_SPRITE_EN
    localparam logic [1:0] LAST_PIX = 2'd3;
`else
    localparam logic [1:0] LAST_PIX = 2'd0;
`endif

    draw_state_e          r_state;
    boid_pix_t            r_tab [N_BOIDS];
    boid_pix_t            r_old;
    logic [IDX_W-1:0]     r_idx;
    logic [15:0]          r_px;
    logic [15:0]          r_py;
    logic [1:0]           r_cnt;
    logic                 r_any;
    logic                 r_ready;

    logic                 w_active;
    logic                 w_on;
    logic                 w_step;
    logic [15:0]          w_sel_px;
    logic [15:0]          w_sel_py;
    logic [FB_ADDR_W-1:0] w_addr;

    // ERASE walks the old position, DRAW the newly latched one
    assign w_sel_px = (r_state == ERASE) ? {6'd0, r_old.px} : r_px;
    assign w_sel_py = (r_state == ERASE) ? {7'd0, r_old.py} : r_py;

    boid_pix_addr #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_pix_addr (
        .px        (w_sel_px),
        .py        (w_sel_py),
        .ofs       (r_cnt),
        .on_screen (w_on),
        .addr      (w_addr)
    );

    assign w_active = (r_state == ERASE) || (r_state == DRAW);
    // Clipped pixels cost a cycle but never wait on the arbiter
    assign w_step   = w_active && (!w_on || !bus.fb_busy);

    assign bus.fb_we     = w_active && w_on && !bus.fb_busy;
    assign bus.fb_addr   = w_active ? w_addr : '0;
    assign bus.fb_data   = (r_state == ERASE) ? BG_COLOR :
                           (r_state == DRAW)  ? BOID_COLOR : 8'h00;
    assign bus.draw_done = (r_state == DONE);
    assign bus.in_ready  = r_ready;

    // Update sequencer and per-boid position table
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_old   <= '0;
            r_idx   <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_cnt   <= '0;
            r_any   <= 1'b0;
            for (int i = 0; i < N_BOIDS; i++) begin
                r_tab[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_ready) begin
                        r_idx   <= bus.in_idx;
                        r_px    <= bus.in_x[31:16];
                        r_py    <= bus.in_y[31:16];
                        r_old   <= r_tab[bus.in_idx];
                        r_cnt   <= '0;
                        r_any   <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= r_tab[bus.in_idx].vld ? ERASE : DRAW;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ERASE: begin
                    if (w_step) begin
                        if (r_cnt == LAST_PIX) begin
                            r_cnt   <= '0;
                            r_state <= DRAW;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                DRAW: begin
                    if (w_step) begin
                        if (w_on) begin
                            r_any <= 1'b1;
                        end
                        if (r_cnt == LAST_PIX) begin
                            r_cnt   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                DONE: begin
                    // An entry only becomes valid if something was actually drawn,
                    // so a fully clipped boid is never erased later
                    r_tab[r_idx] <= '{px: r_px[PX_W-1:0], py: r_py[PY_W-1:0], vld: r_any};
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boid_draw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boid_draw
//  Description : Self-checking bench for boid_draw: table of directed updates
//                with expected writes and latencies, plus reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_boid_draw;
    import boid_draw_pkg::*;

    localparam int IDX_W = 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    boid_draw_if #(.IDX_W(IDX_W)) bus ();

    boid_draw #(.N_BOIDS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_acc   = 0;

    logic [26:0] wq [$];
    int          wlat [$];
    int          dq [$];
    logic [19:0] bq [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write, done pulse and busy-cycle output, labelled by cycle after accept
    always @(negedge clk) begin
        if (bus.fb_we === 1'b1) begin
            wq.push_back({bus.fb_addr, bus.fb_data});
            wlat.push_back(cyc - t_acc + 1);
        end
        if (bus.draw_done === 1'b1) dq.push_back(cyc - t_acc + 1);
        if (bus.fb_busy === 1'b1) bq.push_back({bus.fb_we, bus.fb_addr});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int               idx;
        logic [31:0]      x;
        logic [31:0]      y;
        int               busy;
        int               n_wr;
        logic [7:0][26:0] w;
        int               first_lat;
        int               done_lat;
    } vec_t;

    vec_t vt [$];

    function automatic logic [26:0] W(input int a, input logic [7:0] d);
        logic [31:0] av;
        av = a;
        return {av[18:0], d};
    endfunction

    task automatic add_vec(input int idx, input int xi, input int yi, input logic [15:0] frac,
                           input int busy, input int n, input int fl, input int dl,
                           input logic [26:0] w0, input logic [26:0] w1, input logic [26:0] w2,
                           input logic [26:0] w3, input logic [26:0] w4);
        vec_t v;
        v.idx = idx;
        v.x = (32'(xi) << 16) | {16'd0, frac};
        v.y = (32'(yi) << 16) | {16'd0, frac};
        v.busy = busy;
        v.n_wr = n;
        v.w = '0;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        v.first_lat = fl;
        v.done_lat = dl;
        vt.push_back(v);
    endtask

    // Issue one update, optionally holding fb_busy right after accept, wait for done
    task automatic run_update(input int idx, input logic [31:0] x, input logic [31:0] y, input int busy);
        int g;
        logic [31:0] iv;
        iv = idx;
        @(negedge clk);
        wq.delete(); wlat.delete(); dq.delete(); bq.delete();
        g = 0;
        while (bus.in_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("ready_wait", (g < 50) ? 32'd1 : 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_idx   = iv[IDX_W-1:0];
        bus.in_x     = x;
        bus.in_y     = y;
        t_acc        = cyc + 1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (busy > 0) begin
            bus.fb_busy = 1'b1;
            repeat (busy) @(posedge clk);
            #1;
            bus.fb_busy = 1'b0;
        end
        g = 0;
        while (dq.size() == 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        check("done_wait", (dq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
    endtask

`ifdef BOID_DRAW_SPRITE_EN
    localparam int PRE_DRAW = 4;
    localparam int RST_NW   = 4;
`else
    localparam int PRE_DRAW = 1;
    localparam int RST_NW   = 1;
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_idx   = '0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.fb_busy  = 1'b0;

`ifdef BOID_DRAW_SPRITE_EN
        add_vec(0, 639, 479, 16'h0, 0, 1, 1, 5, W(307199, 8'hFF), '0, '0, '0, '0);
        add_vec(0, 10, 0, 16'h0, 0, 5, 1, 9, W(307199, 8'h00), W(10, 8'hFF), W(11, 8'hFF),
                W(650, 8'hFF), W(651, 8'hFF));
        add_vec(5, 0, 0, 16'h0, 2, 4, 3, 7, W(0, 8'hFF), W(1, 8'hFF), W(640, 8'hFF),
                W(641, 8'hFF), '0);
        add_vec(5, 700, 0, 16'h0, 0, 4, 1, 9, W(0, 8'h00), W(1, 8'h00), W(640, 8'h00),
                W(641, 8'h00), '0);
        add_vec(5, 3, 3, 16'h0, 0, 4, 1, 5, W(1923, 8'hFF), W(1924, 8'hFF), W(2563, 8'hFF),
                W(2564, 8'hFF), '0);
`else
        add_vec(0, 105, 105, 16'h0, 0, 1, 1, 2, W(67305, 8'hFF), '0, '0, '0, '0);
        add_vec(0, 106, 105, 16'h0, 0, 2, 1, 3, W(67305, 8'h00), W(67306, 8'hFF), '0, '0, '0);
        add_vec(0, 106, 105, 16'hFFFF, 0, 2, 1, 3, W(67306, 8'h00), W(67306, 8'hFF), '0, '0, '0);
        add_vec(0, 107, 105, 16'h0, 3, 2, 4, 6, W(67306, 8'h00), W(67307, 8'hFF), '0, '0, '0);
        add_vec(1, 700, 10, 16'h0, 0, 0, 0, 2, '0, '0, '0, '0, '0);
        add_vec(1, 0, 0, 16'h0, 0, 1, 1, 2, W(0, 8'hFF), '0, '0, '0, '0);
        add_vec(1, 639, 479, 16'h0, 0, 2, 1, 3, W(0, 8'h00), W(307199, 8'hFF), '0, '0, '0);
        add_vec(2, 640, 0, 16'h0, 0, 0, 0, 2, '0, '0, '0, '0, '0);
        add_vec(2, 5, 480, 16'h0, 0, 0, 0, 2, '0, '0, '0, '0, '0);
        add_vec(2, 5, 479, 16'h0, 0, 1, 1, 2, W(306565, 8'hFF), '0, '0, '0, '0);
        add_vec(63, 1, 2, 16'h0, 0, 1, 1, 2, W(1281, 8'hFF), '0, '0, '0, '0);
        add_vec(1, 700, 0, 16'h0, 0, 1, 1, 3, W(307199, 8'h00), '0, '0, '0, '0);
        add_vec(1, 10, 0, 16'h0, 0, 1, 1, 2, W(10, 8'hFF), '0, '0, '0, '0);
`endif

        // Reset values while reset is held low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("rst_fb_we",     {31'd0, bus.fb_we},     32'd0);
        check("rst_fb_addr",   {13'd0, bus.fb_addr},   32'd0);
        check("rst_fb_data",   {24'd0, bus.fb_data},   32'd0);
        check("rst_draw_done", {31'd0, bus.draw_done}, 32'd0);
        reset = 1'b1;

        foreach (vt[i]) begin
            run_update(vt[i].idx, vt[i].x, vt[i].y, vt[i].busy);
            check($sformatf("v%0d_nwr", i), 32'(wq.size()), 32'(vt[i].n_wr));
            for (int j = 0; j < vt[i].n_wr; j++) begin
                if (j < wq.size())
                    check($sformatf("v%0d_w%0d", i, j), {5'd0, wq[j]}, {5'd0, vt[i].w[j]});
            end
            if (vt[i].n_wr > 0 && wlat.size() > 0)
                check($sformatf("v%0d_wlat", i), 32'(wlat[0]), 32'(vt[i].first_lat));
            if (dq.size() > 0)
                check($sformatf("v%0d_done", i), 32'(dq[0]), 32'(vt[i].done_lat));
            if (vt[i].busy > 0) begin
                check($sformatf("v%0d_nbusy", i), 32'(bq.size()), 32'(vt[i].busy));
                foreach (bq[k])
                    check($sformatf("v%0d_busy%0d", i, k), {12'd0, bq[k]},
                          {13'd0, vt[i].w[0][26:8]});
            end
        end

        // Reset asserted while in DRAW
        run_update(3, 32'd20 << 16, 32'd20 << 16, 0);
        @(negedge clk);
        begin
            int g;
            g = 0;
            while (bus.in_ready !== 1'b1 && g < 50) begin
                @(negedge clk);
                g++;
            end
            check("rst2_ready_wait", (g < 50) ? 32'd1 : 32'd0, 32'd1);
        end
        bus.in_valid = 1'b1;
        bus.in_idx   = 6'd3;
        bus.in_x     = 32'd21 << 16;
        bus.in_y     = 32'd20 << 16;
        t_acc        = cyc + 1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (PRE_DRAW) @(posedge clk);
        #1;
        check("mid_draw_we", {31'd0, bus.fb_we}, 32'd1);
        check("mid_draw_data", {24'd0, bus.fb_data}, 32'hFF);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_fb_we",    {31'd0, bus.fb_we},     32'd0);
        check("rst_mid_in_ready", {31'd0, bus.in_ready},  32'd0);
        check("rst_mid_done",     {31'd0, bus.draw_done}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
        run_update(3, 32'd22 << 16, 32'd20 << 16, 0);
        check("post_rst_nwr", 32'(wq.size()), 32'(RST_NW));
        if (wq.size() > 0) begin
            check("post_rst_w0", {5'd0, wq[0]}, {5'd0, W(12822, 8'hFF)});
            check("post_rst_wlat", 32'(wlat[0]), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/boid_draw.md
# boid_draw

Framebuffer write stage directly downstream of `boid_accelerator`. It accepts each boid's updated 16.16 fixed-point position over a valid/ready handshake. It erases that boid's previously drawn pixel(s) and draws the new ones into the M10K VGA framebuffer through a single write port shared with the VGA arbiter. A per-boid table remembers each boid's last drawn position, so no full-frame clear is needed.

## Interface
- `N_BOIDS`, 64: number of boids; `IDX_W = $clog2(N_BOIDS)`
- `SCREEN_W`, 640: visible width in pixels
- `SCREEN_H`, 480: visible height in pixels
- `BOID_COLOR`, 8'hFF: draw color
- `BG_COLOR`, 8'h00: erase color

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-low (`reset==0` resets on rising `clk`)
- `in_valid`  in  1  boid update present
- `in_ready`  out  1  stage can accept an update
- `in_idx`  in  IDX_W  boid index
- `in_x`  in  32  x position, unsigned 16.16
- `in_y`  in  32  y position, unsigned 16.16
- `fb_busy`  in  1  arbiter holds the write port; no write allowed
- `fb_we`  out  1  framebuffer write strobe
- `fb_addr`  out  19  `py*SCREEN_W + px`
- `fb_data`  out  8  pixel color
- `draw_done`  out  1  one-cycle pulse when an update completes

## Operation
- Pixel conversion:
  - `px = in_x[31:16]`, `py = in_y[31:16]`; fractional bits are dropped.
  - A pixel is on-screen iff `px < SCREEN_W && py < SCREEN_H`.
  - Off-screen pixels are skipped individually (clipped), never wrapped.
- Address: `(py<<9) + (py<<7) + px`, 19-bit; no multiplier.
- Position table: per boid, `old_px[9:0]`, `old_py[8:0]` and `old_vld`. Reset clears every `old_vld`.
- FSM states: IDLE, ERASE, DRAW, DONE.
  - IDLE: `in_ready=1`. On `in_valid && in_ready`, latch idx/px/py and go to ERASE.
  - ERASE: writes `BG_COLOR` at each on-screen pixel of the old position. Skipped with zero cycles if `old_vld==0`. Then go to DRAW.
  - DRAW: writes `BOID_COLOR` at each on-screen pixel of the new position, then go to DONE.
  - DONE: table entry := latched px/py. `old_vld := 1` if any new pixel was on-screen, else 0. `draw_done=1`; return to IDLE.
- Write handshake:
  - `fb_we = (state is ERASE or DRAW) && pixel on-screen && !fb_busy`.
  - The pixel counter advances only on cycles with `fb_we=1` or a skipped (clipped) pixel.
  - `fb_busy` holds the sequence with `fb_addr`/`fb_data` stable.
- Old position equal to new position: erase, then draw; the final pixel is `BOID_COLOR`.
- Back-to-back updates to the same index are correct, because the table is written in DONE before IDLE.
- Reset mid-operation: return to IDLE, `fb_we=0`, table cleared. Stale pixels are left in the framebuffer (software clears the screen after reset).

## Timing
- Reset values: `in_ready=0` while `reset==0`, then 1 in IDLE; `fb_we=0`; `fb_addr=0`; `fb_data=0`; `draw_done=0`.
- `fb_we`, `fb_addr` and `fb_data` are decoded from registered state plus `fb_busy`. The framebuffer samples them on the same rising edge.
- 1-pixel mode, old valid, both on-screen, no busy:
  - accept at edge T;
  - erase write in cycle T+1;
  - draw write in cycle T+2;
  - `draw_done` in cycle T+3;
  - `in_ready` high in cycle T+4.
- Each `fb_busy` cycle adds exactly one cycle of latency.
- `in_ready` is low from the accept cycle until IDLE is re-entered.

## Configuration
- `BOID_DRAW_SPRITE_EN` defined: each boid is a 2x2 sprite.
  - Pixels are drawn in order (px,py), (px+1,py), (px,py+1), (px+1,py+1), each clipped individually.
  - Erase and draw take up to 4 writes each.
  - Best-case latency: `draw_done` at T+9.
- Undefined: single pixel at (px,py), 1 write per phase.

## Structure
- Package `boid_draw_pkg` holds:
  - `FB_ADDR_W=19`, `PX_W=10`, `PY_W=9`;
  - default screen and color constants;
  - `typedef struct packed {logic [9:0] px; logic [8:0] py; logic vld;} boid_pix_t`;
  - state enum `draw_state_e`.
- One sub-module, `boid_pix_addr`: combinational. Inputs px, py and 2-bit sprite offset; outputs on-screen flag and 19-bit address. It is shared by the ERASE and DRAW phases.

## Test plan
- After reset, update idx 0 at x=105<<16, y=105<<16 → no erase; one write addr 67305, data FF; `draw_done`; table entry valid.
- Same idx, then x=106<<16 → erase write addr 67305 data 00, then draw write addr 67306 data FF.
- Hold `fb_busy` high 3 cycles during ERASE → `fb_we` low and `fb_addr` stable for those cycles; `draw_done` 3 cycles late.
- x=700<<16 → no draw write; `old_vld=0`; the next update of that idx performs no erase.
- With `BOID_DRAW_SPRITE_EN`, x=639<<16, y=479<<16 → exactly one draw write, addr 307199; the 3 clipped pixels are skipped.
- Assert reset during DRAW → next cycle `fb_we=0`, `in_ready=0`. After release, `in_ready=1`, and a new update of that idx does no erase.
